// File: rtl/imc_adc_accumulator_if.sv
// Bus between the IMC ADC accumulator and its controller/back end.
// The controller side drives control and ADC data; the accumulator side returns results and status.
interface imc_adc_accumulator_if #(
    parameter int unsigned NCOL  = 16,
    parameter int unsigned ADC_W = 4,
    parameter int unsigned ACC_W = 9
);
    logic                    start;
    logic                    adc_valid;
    logic [NCOL*ADC_W-1:0]   adc_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [NCOL*ACC_W-1:0]   out_data;
    logic                    busy;
    logic                    overrun;

    modport master (
        output start, adc_valid, adc_in, out_ready,
        input  out_valid, out_data, busy, overrun
    );

    modport slave (
        input  start, adc_valid, adc_in, out_ready,
        output out_valid, out_data, busy, overrun
    );
endinterface

// File: rtl/imc_adc_accumulator.sv
// Bit-serial shift-accumulate stage behind the IMC macro: folds per-plane column ADC codes
// MSB-first into signed per-column dot products and offers them on a valid/ready handshake.
module imc_adc_accumulator #(
    parameter int unsigned NCOL      = 16,
    parameter int unsigned ADC_W     = 4,
    parameter int unsigned IN_BITS   = 4,
    parameter int unsigned SIGNED_IN = 1,
    parameter int unsigned ACC_W     = ADC_W + IN_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imc_adc_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(IN_BITS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q [NCOL];
    logic [ACC_W-1:0] acc_d [NCOL];
    logic [ACC_W-1:0] code_ext [NCOL];
    logic             overrun_q, overrun_d;
    logic             out_valid_q, busy_q;
    logic             take_start;

    // Zero-extended column codes for the current plane
    always_comb begin
        for (int c = 0; c < int'(NCOL); c++) begin
            code_ext[c] = ACC_W'(bus.adc_in[c*ADC_W +: ADC_W]);
        end
    end

    // Next-state, accumulate and overrun logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        acc_d     = acc_q;
        take_start = bus.start &&
                     ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));

        if (bus.adc_valid && (state_q != ACCUM)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: ;
            ACCUM: begin
                if (bus.adc_valid) begin
                    for (int c = 0; c < int'(NCOL); c++) begin
                        if (cnt_q == CNT_FIRST) begin
                            acc_d[c] = (SIGNED_IN != 0) ? (-code_ext[c]) : code_ext[c];
                        end else begin
                            acc_d[c] = (acc_q[c] << 1) + code_ext[c];
                        end
                    end
                    if (cnt_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An accepted START wins over everything above, including a same-cycle overrun
        if (take_start) begin
            state_d   = ACCUM;
            cnt_d     = CNT_FIRST;
            overrun_d = 1'b0;
            for (int c = 0; c < int'(NCOL); c++) begin
                acc_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_FIRST;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int c = 0; c < int'(NCOL); c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            out_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
            for (int c = 0; c < int'(NCOL); c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

    // Accumulators are not touched in HOLD, so they double as the stable result register
    for (genvar g = 0; g < int'(NCOL); g++) begin : g_out
        assign bus.out_data[g*ACC_W +: ACC_W] = acc_q[g];
    end
endmodule

// File: tb/tb_imc_adc_accumulator.sv
// Directed bench for imc_adc_accumulator: a signed and an unsigned instance share one stimulus
// stream; results are compared against hand-computed column values.
module tb_imc_adc_accumulator;
    localparam int unsigned NCOL  = 16;
    localparam int unsigned ADC_W = 4;
    localparam int unsigned ACC_W = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic start, adc_valid, out_ready;
    logic [NCOL*ADC_W-1:0] adc_in;

    int checks = 0;
    int errors = 0;

    imc_adc_accumulator_if #(.NCOL(NCOL), .ADC_W(ADC_W), .ACC_W(ACC_W)) bs ();
    imc_adc_accumulator_if #(.NCOL(NCOL), .ADC_W(ADC_W), .ACC_W(ACC_W)) bu ();

    assign bs.start = start;     assign bu.start = start;
    assign bs.adc_valid = adc_valid; assign bu.adc_valid = adc_valid;
    assign bs.adc_in = adc_in;   assign bu.adc_in = adc_in;
    assign bs.out_ready = out_ready; assign bu.out_ready = out_ready;

    imc_adc_accumulator #(.NCOL(NCOL), .ADC_W(ADC_W), .IN_BITS(4), .SIGNED_IN(1), .ACC_W(ACC_W))
        u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
    imc_adc_accumulator #(.NCOL(NCOL), .ADC_W(ADC_W), .IN_BITS(4), .SIGNED_IN(0), .ACC_W(ACC_W))
        u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bu));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] col(input logic [NCOL*ACC_W-1:0] d, input int c);
        return 32'(d[c*ACC_W +: ACC_W]);
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [NCOL*ADC_W-1:0] data);
        adc_in    = data;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Column 0 and column 15 codes, all other columns zero
    function automatic logic [NCOL*ADC_W-1:0] c0_c15(input logic [3:0] a, input logic [3:0] b);
        logic [NCOL*ADC_W-1:0] v;
        v = '0;
        v[3:0] = a;
        v[NCOL*ADC_W-1 -: ADC_W] = b;
        return v;
    endfunction

    logic [NCOL*ACC_W-1:0] held;

    initial begin
        rst_n = 1'b0; start = 1'b0; adc_valid = 1'b0; out_ready = 1'b0; adc_in = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_valid", 32'(bs.out_valid), 32'd0);
        chk("rst_busy",      32'(bs.busy),      32'd0);
        chk("rst_overrun",   32'(bs.overrun),   32'd0);
        chk("rst_out_data",  32'(|bs.out_data), 32'd0);

        // Signed and unsigned MAC, then 10 cycles of backpressure
        pulse_start();
        chk("busy_after_start", 32'(bs.busy), 32'd1);
        strobe(c0_c15(4'd3, 4'd15));
        strobe(c0_c15(4'd5, 4'd15));
        strobe(c0_c15(4'd7, 4'd15));
        chk("no_valid_before_last", 32'(bs.out_valid), 32'd0);
        strobe(c0_c15(4'd2, 4'd15));
        chk("mac_out_valid", 32'(bs.out_valid), 32'd1);
        chk("s_col0",  col(bs.out_data, 0),  32'h00C);
        chk("s_col15", col(bs.out_data, 15), 32'h1F1);
        chk("s_col7",  col(bs.out_data, 7),  32'h000);
        chk("u_col0",  col(bu.out_data, 0),  32'h03C);
        chk("u_col15", col(bu.out_data, 15), 32'h0E1);
        held = bs.out_data;
        for (int i = 0; i < 10; i++) begin
            adc_in = {$urandom(), $urandom()};
            start  = i[0];
            tick();
            chk("bp_valid", 32'(bs.out_valid), 32'd1);
            chk("bp_data",  32'(bs.out_data == held), 32'd1);
        end
        start = 1'b0;
        chk("bp_overrun", 32'(bs.overrun), 32'd0);
        chk("bp_busy",    32'(bs.busy),    32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_valid_fall", 32'(bs.out_valid), 32'd0);
        chk("hs_busy_fall",  32'(bs.busy),      32'd0);

        // Stray strobe in IDLE, then START together with another stray strobe
        strobe(c0_c15(4'hF, 4'hF));
        chk("ovr_set", 32'(bs.overrun), 32'd1);
        tick(); tick();
        chk("ovr_sticky", 32'(bs.overrun), 32'd1);
        start = 1'b1; adc_valid = 1'b1; adc_in = {NCOL{4'hF}};
        tick();
        start = 1'b0; adc_valid = 1'b0;
        chk("ovr_cleared", 32'(bs.overrun), 32'd0);
        strobe(c0_c15(4'd0, 4'd0));
        strobe(c0_c15(4'd1, 4'd0));
        strobe(c0_c15(4'd2, 4'd0));
        strobe(c0_c15(4'd3, 4'd0));
        chk("ovr_valid", 32'(bs.out_valid), 32'd1);
        chk("ovr_col0",  col(bs.out_data, 0),  32'h00B);
        chk("ovr_col15", col(bs.out_data, 15), 32'h000);

        // Back-to-back: handshake and START in the same HOLD cycle
        out_ready = 1'b1; start = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("b2b_valid_fall", 32'(bs.out_valid), 32'd0);
        chk("b2b_busy",       32'(bs.busy),      32'd1);
        for (int p = 0; p < 4; p++) strobe({NCOL{4'h1}});
        chk("b2b_valid", 32'(bs.out_valid), 32'd1);
        for (int c = 0; c < int'(NCOL); c++) chk($sformatf("b2b_s_col%0d", c), col(bs.out_data, c), 32'h1FF);
        chk("b2b_u_col0", col(bu.out_data, 0), 32'h00F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of ACCUM
        pulse_start();
        strobe(c0_c15(4'd9, 4'd9));
        strobe(c0_c15(4'd9, 4'd9));
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid",   32'(bs.out_valid), 32'd0);
        chk("mid_rst_busy",    32'(bs.busy),      32'd0);
        chk("mid_rst_overrun", 32'(bs.overrun),   32'd0);
        chk("mid_rst_data",    32'(|bs.out_data), 32'd0);
        rst_n = 1'b1;
        tick();
        strobe(c0_c15(4'd1, 4'd1));
        chk("mid_rst_idle", 32'(bs.overrun), 32'd1);
        chk("mid_rst_idle_busy", 32'(bs.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
